// File: rtl/ex_pkg.sv
// Shared op codes and FSM state encoding for the execute stage.
package ex_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD  = 6'h01;
  localparam logic [OP_W-1:0] OP_SUB  = 6'h02;
  localparam logic [OP_W-1:0] OP_SLL  = 6'h03;
  localparam logic [OP_W-1:0] OP_XOR  = 6'h04;
  localparam logic [OP_W-1:0] OP_SRL  = 6'h05;
  localparam logic [OP_W-1:0] OP_OR   = 6'h06;
  localparam logic [OP_W-1:0] OP_AND  = 6'h07;
  localparam logic [OP_W-1:0] OP_LW   = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDI = 6'h09;
  localparam logic [OP_W-1:0] OP_SW   = 6'h0A;
  localparam logic [OP_W-1:0] OP_SRA  = 6'h0B;
  localparam logic [OP_W-1:0] OP_SLT  = 6'h0C;
  localparam logic [OP_W-1:0] OP_MUL  = 6'h0D;
  localparam logic [OP_W-1:0] OP_JAL  = 6'h0E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  // True for the only op that takes the iterative path.
  function automatic logic op_is_mul(input logic [OP_W-1:0] op);
    return (op == OP_MUL);
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, XLEN steps.
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done_c,
  output logic [XLEN-1:0] product_c
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  logic [XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [XLEN-1:0]  step_sum;

  // Next-state: clear beats start, start beats stepping.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (clear) begin
      busy_d = 1'b0;
    end else if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_STEP) begin
        busy_d = 1'b0;
      end
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // Final step's sum is the product; the consumer registers it on the same edge.
  assign busy      = busy_q;
  assign done_c    = busy_q && (cnt_q == LAST_STEP);
  assign product_c = step_sum;

endmodule

// File: rtl/ex_mc.sv
// Multi-cycle execute stage: single-cycle ALU plus iterative MUL behind valid/ready.
module ex_mc
  import ex_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      alu_op,
  input  logic [XLEN-1:0] reg_data1,
  input  logic [XLEN-1:0] reg_data2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  ex_state_e       state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;
  logic            out_valid_q, out_valid_d;

  logic [XLEN-1:0]    alu_res;
  logic               alu_ill;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done_c;
  logic [XLEN-1:0]    mul_product_c;

  assign shamt = reg_data2[SHAMT_W-1:0];

  // Single-cycle ALU; undefined codes yield zero and flag illegal.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_op)
      OP_ADD:                alu_res = reg_data1 + reg_data2;
      OP_SUB:                alu_res = reg_data1 - reg_data2;
      OP_SLL:                alu_res = reg_data1 << shamt;
      OP_XOR:                alu_res = reg_data1 ^ reg_data2;
      OP_SRL:                alu_res = reg_data1 >> shamt;
      OP_OR:                 alu_res = reg_data1 | reg_data2;
      OP_AND:                alu_res = reg_data1 & reg_data2;
      OP_LW, OP_ADDI, OP_SW: alu_res = reg_data1 + imm;
      OP_SRA:                alu_res = XLEN'($signed(reg_data1) >>> shamt);
      OP_SLT:                alu_res = XLEN'($signed(reg_data1) < $signed(reg_data2));
      OP_MUL:                alu_res = '0;
      OP_JAL:                alu_res = pc + XLEN'(4);
      default:               alu_ill = 1'b1;
    endcase
  end

  // Flush blocks acceptance; otherwise ready when empty or when the held result retires.
  assign in_ready = !flush &&
                    ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // Next-state and result capture; flush overrides everything below reset.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    mul_start   = 1'b0;
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      result_d    = '0;
      illegal_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (op_is_mul(alu_op)) begin
              state_d     = ST_BUSY;
              out_valid_d = 1'b0;
              mul_start   = 1'b1;
            end else begin
              state_d     = ST_DONE;
              out_valid_d = 1'b1;
              result_d    = alu_res;
              illegal_d   = alu_ill;
            end
          end else if ((state_q == ST_DONE) && out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
          end
        end
        ST_BUSY: begin
          if (mul_busy && mul_done_c) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            result_d    = mul_product_c;
            illegal_d   = 1'b0;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Stage state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  ex_mul_iter #(
    .XLEN (XLEN)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .start     (mul_start),
    .a         (reg_data1),
    .b         (reg_data2),
    .busy      (mul_busy),
    .done_c    (mul_done_c),
    .product_c (mul_product_c)
  );

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_ex_mc.sv
// Self-checking bench for ex_mc (XLEN=32) against a behavioural op model.
module tb_ex_mc;

  localparam logic [5:0] C_ADD = 6'h01, C_SUB = 6'h02, C_SLL = 6'h03, C_XOR = 6'h04;
  localparam logic [5:0] C_SRL = 6'h05, C_OR = 6'h06, C_AND = 6'h07, C_LW = 6'h08;
  localparam logic [5:0] C_ADDI = 6'h09, C_SW = 6'h0A, C_SRA = 6'h0B, C_SLT = 6'h0C;
  localparam logic [5:0] C_MUL = 6'h0D, C_JAL = 6'h0E;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [5:0]  alu_op;
  logic [31:0] reg_data1, reg_data2, imm, pc, result;

  int total, bad;

  ex_mc #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .reg_data1 (reg_data1),
    .reg_data2 (reg_data2),
    .imm       (imm),
    .pc        (pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {illegal, result} from the architectural definition of each op.
  function automatic logic [32:0] model(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] im,
                                        input logic [31:0] p);
    int unsigned      sh;
    longint unsigned  prod;
    logic [31:0]      r;
    logic             il;
    sh = b % 32;
    r  = 32'd0;
    il = 1'b0;
    case (op)
      C_ADD:                 r = a + b;
      C_SUB:                 r = a - b;
      C_SLL:                 r = a << sh;
      C_XOR:                 r = a ^ b;
      C_SRL:                 r = a >> sh;
      C_OR:                  r = a | b;
      C_AND:                 r = a & b;
      C_LW, C_ADDI, C_SW:    r = a + im;
      C_SRA:                 r = a[31] ? ~((~a) >> sh) : (a >> sh);
      C_SLT:                 r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      C_MUL: begin
        prod = longint'(a) * longint'(b);
        r    = 32'(prod);
      end
      C_JAL:                 r = p + 32'd4;
      default:               il = 1'b1;
    endcase
    return {il, r};
  endfunction

  // Drive one op, wait for its result (bounded), capture it and retire it.
  task automatic issue_one(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] im, input logic [31:0] p,
                           output logic [31:0] res, output logic ill, output bit ok);
    int n;
    ok = 1'b1;
    res = 32'd0;
    ill = 1'b0;
    alu_op = op; reg_data1 = a; reg_data2 = b; imm = im; pc = p;
    in_valid = 1'b1;
    out_ready = 1'b0;
    n = 0;
    #1;
    while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!in_ready) ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    #1;
    while (!out_valid && n < 50) begin @(negedge clk); #1; n++; end
    if (!out_valid) ok = 1'b0;
    res = result;
    ill = illegal;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 6'd0; reg_data1 = 32'd0; reg_data2 = 32'd0; imm = 32'd0; pc = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h expected 0", result); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add_latency;
    @(negedge clk);
    alu_op = C_ADD; reg_data1 = 32'd5; reg_data2 = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || result !== 32'd12 || illegal !== 1'b0) begin
      bad++; $display("FAIL add_latency1: got v=%b r=%h i=%b expected v=1 r=0000000c i=0", out_valid, result, illegal);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_retire: got %b expected 0", out_valid); end
  endtask

  task automatic test_mul_latency;
    int  n;
    bit  rdy_seen;
    @(negedge clk);
    alu_op = C_MUL; reg_data1 = 32'd3; reg_data2 = 32'hFFFF_FFFE; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    rdy_seen = 1'b0;
    #1;
    while (!out_valid && n < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      n++;
      @(negedge clk); #1;
    end
    total++; if (n != 32) begin bad++; $display("FAIL mul_busy_cycles: got %0d expected 32", n); end
    total++; if (rdy_seen) begin bad++; $display("FAIL mul_in_ready_busy: got 1 expected 0"); end
    total++; if (result !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mul_result: got %h expected fffffffa", result); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_directed;
    logic [5:0]  ops[4]  = '{C_SRA, C_SLT, C_SRL, 6'h3F};
    logic [31:0] as[4]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] bs[4]   = '{32'd4, 32'd1, 32'd36, 32'h9ABC_DEF0};
    logic [31:0] exp_r[4] = '{32'hF800_0000, 32'd1, 32'h0800_0000, 32'd0};
    logic        exp_i[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] r;
    logic        il;
    bit          ok;
    for (int i = 0; i < 4; i++) begin
      issue_one(ops[i], as[i], bs[i], 32'd0, 32'd0, r, il, ok);
      total++;
      if (!ok || r !== exp_r[i] || il !== exp_i[i]) begin
        bad++; $display("FAIL directed_op%h: got r=%h i=%b ok=%b expected r=%h i=%b", ops[i], r, il, ok, exp_r[i], exp_i[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q[$];
    logic [31:0] held, exp_v;
    int          retired;
    bit          acc;
    retired = 0;
    held = 32'd0;
    @(negedge clk);
    alu_op = C_ADDI; reg_data1 = $urandom; imm = $urandom; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 8 && c <= 10);
      #1;
      if (out_valid && out_ready) begin
        total++;
        exp_v = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
        if (result !== exp_v) begin bad++; $display("FAIL b2b_result c=%0d: got %h expected %h", c, result, exp_v); end
        retired++;
      end
      if (c == 8) held = result;
      if (c == 9 || c == 10) begin
        total++;
        if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
          bad++; $display("FAIL b2b_stall c=%0d: got r=%h rdy=%b v=%b expected r=%h rdy=0 v=1", c, result, in_ready, out_valid, held);
        end
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(reg_data1 + imm);
      @(negedge clk);
      if (acc) begin reg_data1 = $urandom; imm = $urandom; end
    end
    total++; if (retired != 16) begin bad++; $display("FAIL b2b_throughput: got %0d expected 16", retired); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    if (out_valid) begin
      total++;
      exp_v = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
      if (result !== exp_v) begin bad++; $display("FAIL b2b_drain: got %h expected %h", result, exp_v); end
      retired++;
    end
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (retired != 17 || q.size() != 0) begin
      bad++; $display("FAIL b2b_count: got retired=%0d left=%0d expected 17 0", retired, q.size());
    end
  endtask

  task automatic test_flush;
    bit          seen;
    logic [31:0] a, b, r;
    logic        il;
    bit          ok;
    @(negedge clk);
    alu_op = C_MUL; reg_data1 = $urandom; reg_data2 = $urandom; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; alu_op = C_ADD;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_idle: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); #1; if (out_valid) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("FAIL flush_no_result: got out_valid=1 expected 0"); end
    a = $urandom; b = $urandom;
    issue_one(C_ADD, a, b, 32'd0, 32'd0, r, il, ok);
    total++;
    if (!ok || r !== a + b || il !== 1'b0) begin
      bad++; $display("FAIL flush_next_add: got r=%h ok=%b expected %h", r, ok, a + b);
    end
    flush = 1'b1; in_valid = 1'b1; alu_op = C_ADD;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_idle_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_idle_drop: got %b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul;
    bit          seen;
    logic [31:0] a, b, r;
    logic        il;
    bit          ok;
    @(negedge clk);
    alu_op = C_MUL; reg_data1 = $urandom; reg_data2 = $urandom; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || result !== 32'd0 || illegal !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_mul: got v=%b r=%h i=%b rdy=%b expected 0 0 0 1", out_valid, result, illegal, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); #1; if (out_valid) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("FAIL rst_no_result: got out_valid=1 expected 0"); end
    a = $urandom; b = $urandom;
    issue_one(C_ADD, a, b, 32'd0, 32'd0, r, il, ok);
    total++;
    if (!ok || r !== a + b) begin bad++; $display("FAIL rst_next_add: got %h expected %h", r, a + b); end
  endtask

  task automatic test_random;
    logic [5:0]  op;
    logic [31:0] a, b, im, p, r;
    logic [32:0] exp_v;
    logic        il;
    bit          ok;
    int          muls;
    muls = 0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom_range(15, 63));
      end else begin
        op = 6'($urandom_range(1, 14));
      end
      if (op == C_MUL) begin
        if (muls >= 6) op = C_SUB;
        else muls++;
      end
      a  = $urandom;
      b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
      im = $urandom;
      p  = $urandom;
      issue_one(op, a, b, im, p, r, il, ok);
      exp_v = model(op, a, b, im, p);
      total++;
      if (!ok || r !== exp_v[31:0] || il !== exp_v[32]) begin
        bad++; $display("FAIL random op=%h a=%h b=%h: got r=%h i=%b ok=%b expected r=%h i=%b",
                        op, a, b, r, il, ok, exp_v[31:0], exp_v[32]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_add_latency();
    test_mul_latency();
    test_directed();
    test_back_to_back();
    test_flush();
    test_reset_mid_mul();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
